// File: rtl/reg_file_burst_reader_pkg.sv
// Shared definitions for the register-file burst reader: FSM state encoding
// and the rule for sizing the word-count port and counter.
package reg_file_burst_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2
    } state_e;

    // One extra bit so a full-depth burst (2**ADDR_WIDTH words) is representable.
    function automatic int len_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/reg_file_burst_reader.sv
// Walks a block of consecutive register-file addresses and streams the words
// out on a valid/ready interface, flagging the last word and pulsing done.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for start; zero-length request only pulses done
// ST_LOAD   | rd_addr points at first word; capture it into the output reg
// ST_STREAM | word presented; each handshake loads the next or finishes
module reg_file_burst_reader
    import reg_file_burst_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    localparam int LEN_WIDTH = len_width(ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    state_e                  r_state;
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic [LEN_WIDTH-1:0]    r_remaining;
    logic [DATA_WIDTH-1:0]   r_m_data;
    logic                    r_m_valid;
    logic                    r_m_last;
    logic                    r_done;

    state_e                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   w_ptr_nxt;
    logic [LEN_WIDTH-1:0]    w_remaining_nxt;
    logic [DATA_WIDTH-1:0]   w_m_data_nxt;
    logic                    w_m_valid_nxt;
    logic                    w_m_last_nxt;
    logic                    w_done_nxt;
    logic                    w_load;

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_remaining_nxt = r_remaining;
        w_m_data_nxt    = r_m_data;
        w_m_valid_nxt   = r_m_valid;
        w_m_last_nxt    = r_m_last;
        w_done_nxt      = 1'b0;
        w_load          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        w_ptr_nxt       = base_addr;
                        w_remaining_nxt = length;
                        w_state_nxt     = ST_LOAD;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (r_m_valid && m_ready) begin
                    if (r_m_last) begin
                        w_m_valid_nxt = 1'b0;
                        w_m_last_nxt  = 1'b0;
                        w_done_nxt    = 1'b1;
                        w_state_nxt   = ST_IDLE;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // ptr already points at the next word, so the async read is ready to capture.
        if (w_load) begin
            w_m_data_nxt    = rd_data;
            w_m_valid_nxt   = 1'b1;
            w_m_last_nxt    = (r_remaining == LEN_WIDTH'(1));
            w_ptr_nxt       = r_ptr + ADDR_WIDTH'(1);
            w_remaining_nxt = r_remaining - LEN_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_remaining <= '0;
            r_m_data    <= '0;
            r_m_valid   <= 1'b0;
            r_m_last    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_remaining <= w_remaining_nxt;
            r_m_data    <= w_m_data_nxt;
            r_m_valid   <= w_m_valid_nxt;
            r_m_last    <= w_m_last_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign rd_addr = r_ptr;
    assign m_data  = r_m_data;
    assign m_valid = r_m_valid;
    assign m_last  = r_m_last;
    assign done    = r_done;
    assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_reg_file_burst_reader.sv
// Directed bench for reg_file_burst_reader with a behavioural register file
// preloaded to mem[i] = i ^ 8'hA5.
module tb_reg_file_burst_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [6:0] base_addr;
    logic [7:0] length;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic       busy;
    logic       done;

    logic [7:0] mem [128];
    assign rd_data = mem[rd_addr];

    reg_file_burst_reader #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [6:0] base;
        logic [7:0] len;
        bit         rnd;
        int         mode;   // 0 plain, 1 start injected mid-burst, 2 write mem[5] while stalled on word 2
        logic [7:0] first;
        logic [7:0] lastw;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Starts a burst at the current negedge and consumes it; returns on the done cycle.
    task automatic run_burst(input logic [6:0] b, input logic [7:0] n, input bit rnd,
                             input int mode, input logic [7:0] exp_first, input logic [7:0] exp_lastw);
        logic [7:0] exp_q [$];
        logic [6:0] a;
        logic [7:0] snap_data;
        logic       snap_last;
        logic [6:0] snap_addr;
        bit         stalled;
        bit         r;
        int         idx;
        int         cycles;
        int         stall_cnt;

        for (int i = 0; i < int'(n); i++) begin
            a = b + 7'(i);
            exp_q.push_back(mem[a]);
        end
        if (mode == 2) exp_q[5] = 8'h55;

        start     = 1'b1;
        base_addr = b;
        length    = n;
        tick;
        chk("valid_after_edge1", {31'd0, m_valid}, 32'd0);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        start = 1'b0;
        tick;
        chk("valid_after_edge2", {31'd0, m_valid}, 32'd1);

        idx = 0; cycles = 0; stall_cnt = 0; stalled = 1'b0;
        snap_data = '0; snap_last = 1'b0; snap_addr = '0;
        while (idx < int'(n)) begin
            if (cycles >= 1000) begin
                n_vec++;
                n_err++;
                $display("FAIL burst_timeout: got %0d of %0d words", idx, n);
                break;
            end
            chk("valid_held", {31'd0, m_valid}, 32'd1);
            if (stalled) begin
                chk("stall_data", {24'd0, m_data}, {24'd0, snap_data});
                chk("stall_last", {31'd0, m_last}, {31'd0, snap_last});
                chk("stall_addr", {25'd0, rd_addr}, {25'd0, snap_addr});
            end
            if (mode == 2 && idx == 2 && stall_cnt < 3) begin
                r = 1'b0;
                if (stall_cnt == 0) mem[5] = 8'h55;
                stall_cnt++;
            end else begin
                r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            m_ready = r;
            if (mode == 1 && idx == 1) begin
                start     = 1'b1;
                base_addr = 7'd10;
                length    = 8'd2;
            end else begin
                start = 1'b0;
            end
            if (m_valid && r) begin
                chk("word_data", {24'd0, m_data}, {24'd0, exp_q[idx]});
                chk("word_last", {31'd0, m_last}, (idx == int'(n) - 1) ? 32'd1 : 32'd0);
                a = b + 7'(idx + 1);
                chk("rd_addr", {25'd0, rd_addr}, {25'd0, a});
                if (idx == 0) chk("first_word", {24'd0, m_data}, {24'd0, exp_first});
                if (idx == int'(n) - 1) chk("last_word", {24'd0, m_data}, {24'd0, exp_lastw});
                idx++;
                stalled = 1'b0;
            end else begin
                stalled   = 1'b1;
                snap_data = m_data;
                snap_last = m_last;
                snap_addr = rd_addr;
            end
            tick;
            cycles++;
        end
        start = 1'b0;
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("busy_after_last", {31'd0, busy}, 32'd0);
        chk("valid_after_last", {31'd0, m_valid}, 32'd0);
        chk("last_after_last", {31'd0, m_last}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{7'd3,   8'd4,   1'b0, 0, 8'hA6, 8'hA3};
        tbl[1] = '{7'd3,   8'd4,   1'b1, 0, 8'hA6, 8'hA3};
        tbl[2] = '{7'd126, 8'd4,   1'b0, 0, 8'hDB, 8'hA4};
        tbl[3] = '{7'd0,   8'd128, 1'b0, 0, 8'hA5, 8'hDA};
        tbl[4] = '{7'd0,   8'd128, 1'b1, 0, 8'hA5, 8'hDA};
        tbl[5] = '{7'd127, 8'd1,   1'b0, 0, 8'hDA, 8'hDA};
        tbl[6] = '{7'd100, 8'd50,  1'b1, 0, 8'hC1, 8'hB0};
        tbl[7] = '{7'd3,   8'd4,   1'b0, 1, 8'hA6, 8'hA3};
        tbl[8] = '{7'd0,   8'd8,   1'b0, 2, 8'hA5, 8'hA2};

        for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'hA5;

        rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_last", {31'd0, m_last}, 32'd0);
        chk("rst_addr", {25'd0, rd_addr}, 32'd0);
        chk("rst_data", {24'd0, m_data}, 32'd0);
        rst_n = 1'b1;
        tick;

        for (int v = 0; v < 9; v++) begin
            run_burst(tbl[v].base, tbl[v].len, tbl[v].rnd, tbl[v].mode, tbl[v].first, tbl[v].lastw);
            if (tbl[v].mode == 2) mem[5] = 8'h05 ^ 8'hA5;
            tick;
            chk("done_single_cycle", {31'd0, done}, 32'd0);
            chk("idle_after_burst", {31'd0, busy}, 32'd0);
            chk("no_valid_idle", {31'd0, m_valid}, 32'd0);
        end

        // Zero-length request: done only, no stream.
        start = 1'b1; base_addr = 7'd20; length = 8'd0;
        tick;
        start = 1'b0;
        chk("len0_done", {31'd0, done}, 32'd1);
        chk("len0_busy", {31'd0, busy}, 32'd0);
        chk("len0_valid", {31'd0, m_valid}, 32'd0);
        tick;
        chk("len0_done_clear", {31'd0, done}, 32'd0);
        chk("len0_valid_late", {31'd0, m_valid}, 32'd0);

        // New start accepted in the done cycle of the previous burst.
        run_burst(7'd3, 8'd4, 1'b0, 0, 8'hA6, 8'hA3);
        run_burst(7'd126, 8'd4, 1'b0, 0, 8'hDB, 8'hA4);
        tick;
        chk("b2b_done_clear", {31'd0, done}, 32'd0);

        // Reset in the middle of a stream.
        start = 1'b1; base_addr = 7'd0; length = 8'd128; m_ready = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick;
        chk("pre_rst_valid", {31'd0, m_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, m_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_addr", {25'd0, rd_addr}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        chk("post_rst_done", {31'd0, done}, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        run_burst(7'd3, 8'd4, 1'b1, 0, 8'hA6, 8'hA3);
        tick;
        chk("post_rst_idle", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
